// File: rtl/toy_mem_if.sv
// CPU data bus between the toy CPU (master) and toy_mem (slave).
// Reads are combinational; writes are captured by the slave on its clock.
interface toy_mem_if;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic [7:0] data_out;

  modport master (
    output addr,
    output data_in,
    output we,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  we,
    output data_out
  );
endinterface

// File: rtl/toy_mem.sv
// 16x8 data memory for the toy CPU with a 128-bit scan chain threaded through every bit.
// Define TOY_MEM_RST_CLEAR_EN to have rst also clear the array to zero.
module toy_mem (
  input  logic      clk,
  input  logic      rst,
  input  logic      scan_en,
  input  logic      scan_in,
  output logic      scan_out,
  output logic      scan_done,
  toy_mem_if.slave  bus
);

  localparam int unsigned Depth = 16;

  logic [7:0] mem_q [Depth];
  logic [6:0] scan_cnt_q, scan_cnt_d;
  logic       scan_done_q, scan_done_d;

  assign bus.data_out = mem_q[bus.addr];
  assign scan_out     = mem_q[Depth-1][7];
  assign scan_done    = scan_done_q;

  // Chain runs mem[0] LSB -> mem[0] MSB -> mem[1] LSB ... -> mem[15] MSB -> scan_out.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef TOY_MEM_RST_CLEAR_EN
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
`endif
    end else if (scan_en) begin
      mem_q[0] <= {mem_q[0][6:0], scan_in};
      for (int i = 1; i < Depth; i++) begin
        mem_q[i] <= {mem_q[i][6:0], mem_q[i-1][7]};
      end
    end else if (bus.we) begin
      mem_q[bus.addr] <= bus.data_in;
    end
  end

  always_comb begin
    scan_cnt_d  = '0;
    scan_done_d = 1'b0;
    if (!rst && scan_en) begin
      scan_cnt_d  = scan_cnt_q + 7'd1;
      scan_done_d = (scan_cnt_q == 7'd127);
    end
  end

  always_ff @(posedge clk) begin
    scan_cnt_q  <= scan_cnt_d;
    scan_done_q <= scan_done_d;
  end

endmodule

// File: tb/tb_toy_mem.sv
// Scoreboard bench for toy_mem: driver pushes expected outputs from a byte/bit-vector model,
// a monitor pops and compares them every cycle.
module tb_toy_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en = 1'b0;
  logic scan_in = 1'b0;
  logic scan_out;
  logic scan_done;

  toy_mem_if bus ();

  toy_mem dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .scan_done (scan_done),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         chk_data;
    logic       so;
    bit         chk_so;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;

  // Reference model: bytes plus a run length of consecutive shifts.
  logic [7:0] m_mem [16];
  bit         m_known [16];
  int         m_run = 0;
  logic       m_done = 1'b0;

  function automatic logic [127:0] pack_mem();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = m_mem[k];
    return v;
  endfunction

  task automatic unpack_mem(input logic [127:0] v);
    for (int k = 0; k < 16; k++) m_mem[k] = v[8*k +: 8];
  endtask

  task automatic cycle(input logic r, input logic se, input logic si, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    logic [127:0] v;
    @(negedge clk);
    rst = r;
    scan_en = se;
    scan_in = si;
    bus.we = w;
    bus.addr = a;
    bus.data_in = d;
    #1;
    e.data = m_mem[a];
    e.chk_data = m_known[a];
    e.so = m_mem[15][7];
    e.chk_so = m_known[15];
    e.done = m_done;
    q.push_back(e);
    if (r) begin
      m_run = 0;
      m_done = 1'b0;
`ifdef TOY_MEM_RST_CLEAR_EN
      for (int k = 0; k < 16; k++) begin
        m_mem[k] = 8'h00;
        m_known[k] = 1'b1;
      end
`endif
    end else if (se) begin
      v = pack_mem();
      v = {v[126:0], si};
      unpack_mem(v);
      m_run++;
      m_done = ((m_run % 128) == 0);
    end else begin
      m_run = 0;
      m_done = 1'b0;
      if (w) begin
        m_mem[a] = d;
        m_known[a] = 1'b1;
      end
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'(a), 8'h00);
  endtask

  task automatic scan_n(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'h0, 8'h00);
  endtask

  // Monitor: samples between the driver's input change and the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (scan_done === 1'b1) done_seen++;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (scan_done !== e.done) begin
          n_bad++;
          $display("FAIL scan_done: got %b expected %b at %0t", scan_done, e.done, $time);
        end
        if (e.chk_data) begin
          n_cmp++;
          if (bus.data_out !== e.data) begin
            n_bad++;
            $display("FAIL data_out[%0d]: got %02h expected %02h at %0t",
                     bus.addr, bus.data_out, e.data, $time);
          end
        end
        if (e.chk_so) begin
          n_cmp++;
          if (scan_out !== e.so) begin
            n_bad++;
            $display("FAIL scan_out: got %b expected %b at %0t", scan_out, e.so, $time);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pat;
    bus.we = 1'b0;
    bus.addr = 4'h0;
    bus.data_in = 8'h00;
    for (int k = 0; k < 16; k++) begin
      m_mem[k] = 8'h00;
      m_known[k] = 1'b0;
    end

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00);

    // Initialise every byte, then the directed A5 write and readback.
    for (int a = 0; a < 16; a++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'(a), 8'($urandom));
    read_all();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 8'hA5);
    read_all();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 8'h11);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 8'h22);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 8'h00);

    // Scan load: mem[k] = 0x10+k, mem[15] MSB first.
    for (int k = 0; k < 16; k++) pat[8*k +: 8] = 8'(8'h10 + k);
    for (int j = 0; j < 128; j++) cycle(1'b0, 1'b1, pat[127-j], 1'b0, 4'h0, 8'h00);
    read_all();

    // Dump with zeros in.
    for (int j = 0; j < 128; j++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    read_all();

    // Write collides with scan: only the shift happens.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h5A);
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 1'(j), 1'b1, 4'h0, 8'hFF);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);

    // Abort and resume: exactly one done pulse.
    done_seen = 0;
    scan_n(60);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    scan_n(128);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    #3;
    n_cmp++;
    if (done_seen != 1) begin
      n_bad++;
      $display("FAIL abort_pulses: got %0d expected 1", done_seen);
    end

    // Reset at count 100 during a scan, then resume.
    scan_n(100);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 8'hEE);
    scan_n(130);
    read_all();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 8'h33);
    read_all();

    // Random mix.
    for (int j = 0; j < 400; j++) begin
      cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom));
    end
    read_all();

    for (int j = 0; j < 4 && q.size() > 0; j++) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toy_mem.md
# toy_mem

16×8 byte memory acting as the responder on the toy CPU's data bus: it answers CPU reads combinationally and captures CPU writes on the clock edge. It also carries a 128-bit serial scan chain through the whole array, so the same scan pins that observe the CPU can preload a program and dump memory contents. It sits beside `cpu` in the top wrapper, sharing its clock, reset and scan enable.

## Interface

Parameters: none; depth 16, width 8 fixed.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `scan_en`  input  1  1 = shift the scan chain this cycle; bus writes are ignored.
- `scan_in`  input  1  serial scan data in.
- `scan_out`  output  1  serial scan data out; always equals `mem[15][7]`.
- `scan_done`  output  1  registered one-cycle pulse after the 128th consecutive shift.
- `addr`  input  4  byte address from the CPU.
- `data_in`  input  8  write data from the CPU (CPU `data_out`).
- `we`  input  1  write enable from the CPU.
- `data_out`  output  8  read data to the CPU (CPU `data_in`); equals `mem[addr]`.

## Operation

- Storage: `mem[0..15]`, each 8 bits.
- Read: `data_out = mem[addr]`, combinational, independent of `we` and `scan_en`.
- Write: when `!rst && !scan_en && we`, then `mem[addr] <= data_in` at the edge. The new value is visible on `data_out` in the next cycle; same-cycle read returns the old value.
- Scan shift: when `!rst && scan_en`, the whole array shifts one bit per cycle:
  - `mem[0][0] <= scan_in`
  - `mem[i][b+1] <= mem[i][b]` for b = 0..6
  - `mem[i+1][0] <= mem[i][7]` for i = 0..14
  - `mem[15][7]` is shifted out and lost.
- Load order: 128 shifts fully replace contents. The first bit shifted in ends at `mem[15][7]`. Serial order is therefore `mem[15]` MSB first, down to `mem[0]` LSB last.
- Dump order: `scan_out` presents old contents in the same order, so load and dump run simultaneously.
- Scan counter `scan_cnt` (7 bits):
  - Increments on each shift and wraps 127→0.
  - Clears whenever `scan_en` = 0 or `rst` = 1.
  - `scan_done` <= 1 on the cycle following the shift where `scan_cnt` was 127; 0 otherwise.
  - A continuous 256-cycle scan pulses `scan_done` twice.
- Priority: `rst` > `scan_en` > `we`.

## Timing

- Reset values: `scan_done` = 0, `scan_cnt` = 0. `data_out` and `scan_out` follow memory contents (see Configuration).
- Read latency: 0 cycles. Write latency: 1 edge.
- `scan_done` asserts 128 edges after the first shift edge of an unbroken `scan_en` run, for exactly one cycle.
- `scan_en` deasserted mid-run: shifted bits remain where they are, the counter clears, and no `scan_done` is produced. Resuming restarts the count at 0.
- `rst` mid-scan or mid-write: this cycle's shift/write is suppressed, the counter clears, and `scan_done` = 0 next cycle.
- `we` asserted together with `scan_en`: the write is dropped and only the shift happens.
- Writes to the same address on consecutive cycles: last write wins.

## Configuration

- `TOY_MEM_RST_CLEAR_EN` defined: `rst` also clears all 16 bytes to 0x00. After reset, `data_out` = 0x00 and `scan_out` = 0.
- Undefined: `rst` affects only `scan_cnt`/`scan_done`. Memory contents survive reset, so a scanned-in program persists across CPU reset. Memory power-up contents are X.

## Test plan

- Write/read: `we`=1, `addr`=3, `data_in`=0xA5 for one cycle; then `addr`=3 -> `data_out`=0xA5 next cycle, and the other addresses keep their prior values.
- Scan load: 128 shifts of the pattern `mem[k]`=0x10+k (order: `mem[15]` MSB first … `mem[0]` LSB last). Then reading `addr` 0..15 -> 0x10..0x1F. `scan_done`=1 exactly on cycle 129 only.
- Scan dump: preload by scan, then shift 128 more cycles with `scan_in`=0 -> `scan_out` stream reproduces the loaded bytes in load order. Afterwards all bytes = 0x00, and `scan_done` pulses again.
- Priority: `scan_en`=1 and `we`=1, `addr`=0, `data_in`=0xFF -> `mem[0]` changes only by the shift (LSB = `scan_in`), not to 0xFF.
- Abort: `scan_en` high for 60 cycles, low for 1, high for 128 -> a single `scan_done` pulse, 128 cycles after the resume.
- Reset: `rst` asserted during scan at count 100 -> `scan_done` stays 0 and the count restarts. With `TOY_MEM_RST_CLEAR_EN`, all reads return 0x00; without it, contents are unchanged.
